// File: rtl/gpio_loader_pkg.sv
// Shared definitions for the GPIO serial configuration loader:
// the loader FSM state encoding and the default per-stage word width.
package gpio_loader_pkg;

    localparam int PAD_CTRL_BITS_DEFAULT = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LOAD     = 3'd3,
        DONE     = 3'd4
    } loader_state_t;

endpackage

// File: rtl/gpio_cfg_regfile.sv
// Shadow copies of every stage's configuration word: one write port,
// one asynchronous read port, power-on contents taken from gpio_defaults.
module gpio_cfg_regfile
    import gpio_loader_pkg::*;
#(
    parameter int NUM_IO        = 19,
    parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DEFAULT,
    parameter int IDX_W         = 5
) (
    input  logic                            serial_clock,
    input  logic                            resetn,
    input  logic [NUM_IO*PAD_CTRL_BITS-1:0] gpio_defaults,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [PAD_CTRL_BITS-1:0]        wr_data,
    input  logic [IDX_W-1:0]                rd_idx,
    output logic [PAD_CTRL_BITS-1:0]        rd_data
);

    logic [PAD_CTRL_BITS-1:0] words [NUM_IO];

    // NOTE: this array is reset on purpose -- each word must come back to its
    // power-on default -- so it maps to flops rather than a RAM macro.
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_IO; i++)
                words[i] <= gpio_defaults[i*PAD_CTRL_BITS +: PAD_CTRL_BITS];
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_data = words[rd_idx];

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts the shadow configuration words into a chain of gpio_control_block
// stages (highest stage first, MSB first), then pulses the chain load.
module gpio_serial_loader
    import gpio_loader_pkg::*;
#(
    parameter int   NUM_IO        = 19,
    parameter int   PAD_CTRL_BITS = PAD_CTRL_BITS_DEFAULT,
    localparam int  IDX_W         = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
    input  logic                            serial_clock,
    input  logic                            resetn,
    input  logic [NUM_IO*PAD_CTRL_BITS-1:0] gpio_defaults,
    input  logic                            cfg_wr,
    input  logic [IDX_W-1:0]                cfg_idx,
    input  logic [PAD_CTRL_BITS-1:0]        cfg_data,
    input  logic                            xfer_start,
    output logic                            busy,
    output logic                            done,
    output logic                            chain_clock,
    output logic                            chain_load,
    output logic                            chain_data
);

    localparam int BIT_W = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
    localparam logic [IDX_W-1:0] WPTR_LAST  = IDX_W'(NUM_IO - 1);
    localparam logic [BIT_W-1:0] BPTR_LAST  = BIT_W'(PAD_CTRL_BITS - 1);
    localparam logic [IDX_W:0]   IDX_LIMIT  = (IDX_W + 1)'(NUM_IO);

    loader_state_t            state, state_next;
    logic [IDX_W-1:0]         wptr, wptr_next;
    logic [BIT_W-1:0]         bptr, bptr_next;
    logic                     wr_accept;
    logic [PAD_CTRL_BITS-1:0] rd_word;
    logic                     clock_next, load_next, data_next;

    assign wr_accept = cfg_wr && ((state == IDLE) || (state == DONE))
                       && ({1'b0, cfg_idx} < IDX_LIMIT);

    gpio_cfg_regfile #(
        .NUM_IO       (NUM_IO),
        .PAD_CTRL_BITS(PAD_CTRL_BITS),
        .IDX_W        (IDX_W)
    ) u_regfile (
        .serial_clock (serial_clock),
        .resetn       (resetn),
        .gpio_defaults(gpio_defaults),
        .wr_en        (wr_accept),
        .wr_idx       (cfg_idx),
        .wr_data      (cfg_data),
        .rd_idx       (wptr_next),
        .rd_data      (rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            wptr  <= '0;
            bptr  <= '0;
        end else begin
            state <= state_next;
            wptr  <= wptr_next;
            bptr  <= bptr_next;
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        wptr_next  = wptr;
        bptr_next  = bptr;
        case (state)
            IDLE: begin
                if (xfer_start) begin
                    state_next = SHIFT_LO;
                    wptr_next  = WPTR_LAST;
                    bptr_next  = BPTR_LAST;
                end
            end
            SHIFT_LO: state_next = SHIFT_HI;
            SHIFT_HI: begin
                if (wptr == '0 && bptr == '0) begin
                    state_next = LOAD;
                end else begin
                    state_next = SHIFT_LO;
                    if (bptr == '0) begin
                        bptr_next = BPTR_LAST;
                        wptr_next = wptr - 1'b1;
                    end else begin
                        bptr_next = bptr - 1'b1;
                    end
                end
            end
            LOAD:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Chain pins are computed for the upcoming state and registered below; the
    // first bit forwards a same-cycle write so the transfer sees the new word.
    always_comb begin
        busy       = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LOAD);
        done       = (state == DONE);
        clock_next = (state_next == SHIFT_HI);
        load_next  = (state_next == LOAD);
        data_next  = 1'b0;
        if (state_next == SHIFT_LO) begin
            if (wr_accept && cfg_idx == wptr_next)
                data_next = cfg_data[bptr_next];
            else
                data_next = rd_word[bptr_next];
        end else if (state_next == SHIFT_HI) begin
            data_next = chain_data;
        end
    end

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            chain_clock <= 1'b0;
            chain_load  <= 1'b0;
            chain_data  <= 1'b0;
        end else begin
            chain_clock <= clock_next;
            chain_load  <= load_next;
            chain_data  <= data_next;
        end
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench: a two-stage loader driving a behavioural chain model, plus a
// three-stage instance for an out-of-range write index.
module tb_gpio_serial_loader;

    logic        serial_clock = 1'b0;
    logic        resetn       = 1'b0;
    logic [19:0] gpio_defaults = {10'h155, 10'h2AA};
    logic        cfg_wr = 1'b0;
    logic [0:0]  cfg_idx = '0;
    logic [9:0]  cfg_data = '0;
    logic        xfer_start = 1'b0;
    logic        busy, done, chain_clock, chain_load, chain_data;

    logic [11:0] gpio_defaults3 = {4'hC, 4'h5, 4'h9};
    logic        cfg_wr3 = 1'b0;
    logic [1:0]  cfg_idx3 = '0;
    logic [3:0]  cfg_data3 = '0;
    logic        xfer_start3 = 1'b0;
    logic        busy3, done3, chain_clock3, chain_load3, chain_data3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 serial_clock = ~serial_clock;

    gpio_serial_loader #(.NUM_IO(2), .PAD_CTRL_BITS(10)) u_dut (
        .serial_clock (serial_clock), .resetn(resetn), .gpio_defaults(gpio_defaults),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .xfer_start(xfer_start),
        .busy(busy), .done(done), .chain_clock(chain_clock), .chain_load(chain_load),
        .chain_data(chain_data)
    );

    gpio_serial_loader #(.NUM_IO(3), .PAD_CTRL_BITS(4)) u_dut3 (
        .serial_clock (serial_clock), .resetn(resetn), .gpio_defaults(gpio_defaults3),
        .cfg_wr(cfg_wr3), .cfg_idx(cfg_idx3), .cfg_data(cfg_data3), .xfer_start(xfer_start3),
        .busy(busy3), .done(done3), .chain_clock(chain_clock3), .chain_load(chain_load3),
        .chain_data(chain_data3)
    );

    // Chain model: stage 0 takes chain_data, each stage passes its MSB on;
    // {stage1, stage0} is one shift register, latched on chain_load.
    logic [19:0] chain_sr = '0, chain_latched = '0;
    int          shift_count = 0, load_count = 0;
    always @(posedge chain_clock) begin
        chain_sr    <= {chain_sr[18:0], chain_data};
        shift_count <= shift_count + 1;
    end
    always @(posedge chain_load) begin
        chain_latched <= chain_sr;
        load_count    <= load_count + 1;
    end

    logic [11:0] chain3_sr = '0, chain3_latched = '0;
    always @(posedge chain_clock3) chain3_sr <= {chain3_sr[10:0], chain_data3};
    always @(posedge chain_load3)  chain3_latched <= chain3_sr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [0:0] idx, input logic [9:0] data);
        @(negedge serial_clock);
        cfg_wr = 1'b1; cfg_idx = idx; cfg_data = data;
        @(negedge serial_clock);
        cfg_wr = 1'b0;
    endtask

    // One transfer on the main DUT. Optionally writes alongside the start,
    // injects a write+start at busy cycle inject_at, or resets at busy cycle abort_at.
    task automatic run_xfer(input logic wr, input logic [0:0] widx, input logic [9:0] wdata,
                            input int inject_at, input int abort_at,
                            output int n_busy, output int n_done, output int load_at,
                            output int done_at, output int overlap, output int done_pins);
        bit seen_done = 0;
        n_busy = 0; n_done = 0; load_at = -1; done_at = -2; overlap = 0; done_pins = 0;
        @(negedge serial_clock);
        xfer_start = 1'b1; cfg_wr = wr; cfg_idx = widx; cfg_data = wdata;
        @(negedge serial_clock);
        xfer_start = 1'b0; cfg_wr = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (seen_done && !done) break;
            if (busy) n_busy++;
            if (chain_load) load_at = c;
            if (chain_load && chain_clock) overlap++;
            if (done) begin
                n_done++; done_at = c; seen_done = 1;
                done_pins = {chain_clock, chain_load, chain_data};
            end
            if (abort_at > 0 && busy && n_busy == abort_at) begin
                resetn = 1'b0;
                #1;
                check("abort_pins_zero", {busy, done, chain_clock, chain_load, chain_data}, 5'b0);
                break;
            end
            if (c == inject_at) begin
                cfg_wr = 1'b1; cfg_idx = 1'b0; cfg_data = 10'h0F0; xfer_start = 1'b1;
            end else begin
                cfg_wr = 1'b0; xfer_start = 1'b0;
            end
            @(negedge serial_clock);
        end
        cfg_wr = 1'b0; xfer_start = 1'b0;
    endtask

    int nb, nd, la, da, ov, dp, s0, l0, idle_busy;

    initial begin
        repeat (3) @(negedge serial_clock);
        check("reset_pins", {busy, done, chain_clock, chain_load, chain_data}, 5'b0);
        resetn = 1'b1;
        @(negedge serial_clock);
        check("idle_pins", {busy, done, chain_clock, chain_load, chain_data}, 5'b0);

        // Defaults {0x155, 0x2AA}
        s0 = shift_count; l0 = load_count;
        run_xfer(0, 0, 0, -1, 0, nb, nd, la, da, ov, dp);
        check("dflt_busy_cycles", nb, 41);
        check("dflt_done_cycles", nd, 1);
        check("dflt_shifts", shift_count - s0, 20);
        check("dflt_stream", chain_sr, 20'h556AA);
        check("dflt_loads", load_count - l0, 1);
        check("dflt_done_pins", dp, 0);

        // Stage 1 = 0x3FF: ten ones, then 0x2AA
        do_write(1'b1, 10'h3FF);
        s0 = shift_count; l0 = load_count;
        run_xfer(0, 0, 0, -1, 0, nb, nd, la, da, ov, dp);
        check("w1_stream", chain_sr, 20'hFFEAA);
        check("w1_loads", load_count - l0, 1);
        check("w1_done_after_load", da, la + 1);
        check("w1_load_clock_overlap", ov, 0);

        // Chain latches each stage's word
        do_write(1'b0, 10'h001);
        do_write(1'b1, 10'h200);
        run_xfer(0, 0, 0, -1, 0, nb, nd, la, da, ov, dp);
        check("chain_stage0", chain_latched[9:0], 10'h001);
        check("chain_stage1", chain_latched[19:10], 10'h200);

        // Write and start while busy are ignored
        s0 = shift_count; l0 = load_count;
        run_xfer(0, 0, 0, 5, 0, nb, nd, la, da, ov, dp);
        check("busy_ign_width", nb, 41);
        check("busy_ign_stream", chain_sr, 20'h80001);
        idle_busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) idle_busy++;
            @(negedge serial_clock);
        end
        check("busy_ign_no_restart", idle_busy, 0);
        run_xfer(0, 0, 0, -1, 0, nb, nd, la, da, ov, dp);
        check("busy_ign_shadow", chain_sr, 20'h80001);

        // Write and start in the same idle cycle: new word is sent
        run_xfer(1, 1'b0, 10'h155, -1, 0, nb, nd, la, da, ov, dp);
        check("same_cycle_stream", chain_sr, 20'h80155);
        check("same_cycle_busy", nb, 41);

        // Reset at busy cycle 17
        l0 = load_count;
        run_xfer(0, 0, 0, -1, 17, nb, nd, la, da, ov, dp);
        repeat (2) @(negedge serial_clock);
        resetn = 1'b1;
        repeat (3) @(negedge serial_clock);
        check("abort_no_load", load_count - l0, 0);
        check("abort_idle_pins", {busy, done, chain_clock, chain_load, chain_data}, 5'b0);
        run_xfer(0, 0, 0, -1, 0, nb, nd, la, da, ov, dp);
        check("abort_defaults", chain_sr, 20'h556AA);

        // Out-of-range index on the three-stage instance is ignored
        @(negedge serial_clock);
        cfg_wr3 = 1'b1; cfg_idx3 = 2'd3; cfg_data3 = 4'hF;
        @(negedge serial_clock);
        cfg_wr3 = 1'b0; xfer_start3 = 1'b1;
        @(negedge serial_clock);
        xfer_start3 = 1'b0;
        nb = 0;
        for (int c = 0; c < 100 && !done3; c++) begin
            if (busy3) nb++;
            @(negedge serial_clock);
        end
        check("oor_done_seen", done3, 1'b1);
        check("oor_busy_cycles", nb, 25);
        check("oor_stream", chain3_sr, 12'hC59);
        check("oor_latched", chain3_latched, 12'hC59);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
